// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg: shared FSM state encoding and parity modes
// for the serial parity generator and checker.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_checker_sat_counter.sv
// sat_counter: up counter that sticks at all-ones,
// cleared only by the asynchronous reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, hold once the maximum value is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// serial_parity_checker: deserialises LSB-first frames and checks parity.
// Define SERIAL_PARITY_ERRCNT_EN to add the saturating err_count output.
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter bit ODD_PARITY = PAR_EVEN
`ifdef SERIAL_PARITY_ERRCNT_EN
    ,
    parameter int ERR_CNT_W  = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 x,
    input  logic                 x_valid,
    input  logic                 sof,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_done,
    output logic                 parity_err,
    output logic                 busy
`ifdef SERIAL_PARITY_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam int            CW      = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST    = CW'(DATA_BITS - 1);
    localparam bit            EXP_PAR = ODD_PARITY ? PAR_ODD : PAR_EVEN;

    state_t                 state;
    state_t                 state_d;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_d;
    logic                   acc;
    logic                   acc_d;
    logic [DATA_BITS-1:0]   shift;
    logic [DATA_BITS-1:0]   shift_d;
    logic [DATA_BITS-1:0]   data_d;
    logic                   perr_d;
    logic                   done_d;

    // Register FSM state, shift register and the per-frame results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            acc        <= 1'b0;
            shift      <= '0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            acc        <= acc_d;
            shift      <= shift_d;
            data_out   <= data_d;
            parity_err <= perr_d;
            frame_done <= done_d;
        end
    end

    // Next-state logic: sof always restarts, otherwise walk the frame.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        acc_d   = acc;
        shift_d = shift;
        data_d  = data_out;
        perr_d  = parity_err;
        done_d  = 1'b0;
        if (x_valid && sof) begin
            shift_d[0] = x;
            acc_d      = x;
            cnt_d      = CW'(1);
            state_d    = ST_DATA;
        end else if (x_valid) begin
            unique case (state)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_DATA: begin
                    shift_d[cnt] = x;
                    acc_d        = acc ^ x;
                    if (cnt == LAST) begin
                        cnt_d   = '0;
                        state_d = ST_PARITY;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                ST_PARITY: begin
                    data_d  = shift;
                    perr_d  = (acc ^ x) != EXP_PAR;
                    done_d  = 1'b1;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef SERIAL_PARITY_ERRCNT_EN
    // Count failed frames on the same edge that publishes the result.
    sat_counter #(
        .W     (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (done_d && perr_d),
        .count (err_count)
    );
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker: directed and random frames on an even and an odd
// parity checker, compared against a queue-based frame model.
module tb_serial_parity_checker;

    localparam int DB  = 8;
    localparam int ECW = 2;
    localparam int ECM = (1 << ECW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          x = 1'b0;
    logic          x_valid = 1'b0;
    logic          sof = 1'b0;
    logic [DB-1:0] dout_e;
    logic [DB-1:0] dout_o;
    logic          done_e;
    logic          done_o;
    logic          perr_e;
    logic          perr_o;
    logic          busy_e;
    logic          busy_o;
`ifdef SERIAL_PARITY_ERRCNT_EN
    logic [ECW-1:0] ecnt_e;
    logic [ECW-1:0] ecnt_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    bit            q[$];
    logic [DB-1:0] e_data;
    bit            e_done;
    bit            e_pe;
    bit            e_po;
    bit            e_busy;
    int            e_ce;
    int            e_co;

    always #5 clk = ~clk;

    serial_parity_checker #(
        .DATA_BITS  (DB),
        .ODD_PARITY (1'b0)
`ifdef SERIAL_PARITY_ERRCNT_EN
        ,
        .ERR_CNT_W  (ECW)
`endif
    ) u_even (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .x_valid    (x_valid),
        .sof        (sof),
        .data_out   (dout_e),
        .frame_done (done_e),
        .parity_err (perr_e),
        .busy       (busy_e)
`ifdef SERIAL_PARITY_ERRCNT_EN
        ,
        .err_count  (ecnt_e)
`endif
    );

    serial_parity_checker #(
        .DATA_BITS  (DB),
        .ODD_PARITY (1'b1)
`ifdef SERIAL_PARITY_ERRCNT_EN
        ,
        .ERR_CNT_W  (ECW)
`endif
    ) u_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .x_valid    (x_valid),
        .sof        (sof),
        .data_out   (dout_o),
        .frame_done (done_o),
        .parity_err (perr_o),
        .busy       (busy_o)
`ifdef SERIAL_PARITY_ERRCNT_EN
        ,
        .err_count  (ecnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("even.data_out", 32'(dout_e), 32'(e_data));
        check("even.frame_done", 32'(done_e), 32'(e_done));
        check("even.parity_err", 32'(perr_e), 32'(e_pe));
        check("even.busy", 32'(busy_e), 32'(e_busy));
        check("odd.data_out", 32'(dout_o), 32'(e_data));
        check("odd.frame_done", 32'(done_o), 32'(e_done));
        check("odd.parity_err", 32'(perr_o), 32'(e_po));
        check("odd.busy", 32'(busy_o), 32'(e_busy));
`ifdef SERIAL_PARITY_ERRCNT_EN
        check("even.err_count", 32'(ecnt_e), 32'(e_ce));
        check("odd.err_count", 32'(ecnt_o), 32'(e_co));
`endif
    endtask

    // one clock: check what the last edge produced, then present a bit
    task automatic drive(input bit v, input bit s, input bit b);
        bit par;
        logic [DB-1:0] w;
        @(negedge clk);
        check_outputs();
        x_valid = v;
        sof = s;
        x = b;
        e_done = 1'b0;
        if (v && s) begin
            q.delete();
            q.push_back(b);
        end else if (v && q.size() != 0) begin
            q.push_back(b);
            if (q.size() == DB + 1) begin
                par = 1'b0;
                w = '0;
                for (int i = 0; i <= DB; i++) begin
                    par ^= q[i];
                    if (i < DB) w[i] = q[i];
                end
                e_data = w;
                e_done = 1'b1;
                e_pe = par;
                e_po = ~par;
                if (par && e_ce < ECM) e_ce++;
                if (!par && e_co < ECM) e_co++;
                q.delete();
            end
        end
        e_busy = (q.size() != 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        x_valid = 1'b0;
        sof = 1'b0;
        x = 1'b0;
        q.delete();
        e_data = '0;
        e_done = 1'b0;
        e_pe = 1'b0;
        e_po = 1'b0;
        e_busy = 1'b0;
        e_ce = 0;
        e_co = 0;
        #1;
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [DB-1:0] w, input bit p,
                              input int gap);
        for (int i = 0; i < DB; i++) begin
            drive(1'b1, i == 0, w[i]);
            repeat (gap) drive(1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, p);
    endtask

    initial begin
        do_reset();

        send_frame(8'hA5, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 0);
        drive(1'b0, 1'b0, 1'b0);
        send_frame(8'h01, 1'b0, 3);
        drive(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 1'b1);
        send_frame(8'h3C, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, i[0]);
        do_reset();
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) send_frame(8'h5A, 1'b1, 0);
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_frame(8'h5A, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 9) < 7,
                      $urandom_range(0, 11) == 0,
                      1'($urandom));
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Receive-side counterpart of the running serial parity generator.
- Deserialises a framed bit stream of DATA_BITS data bits followed by one parity bit.
- Recomputes the running parity, then reports the recovered word and a pass/fail flag once per frame.
- Sits at the receive end of the serial link and feeds the downstream word consumer.

Parameters:
- DATA_BITS, 8, data bits per frame. Legal range is 2..32.
- ODD_PARITY, 0. 0 means even parity (the XOR of data and parity bits must be 0). 1 means odd parity (the XOR must be 1).
- ERR_CNT_W, 8, width of the saturating error counter. Only used when the optional feature is enabled.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- x  input  1  serial data/parity bit. Sampled only when x_valid=1.
- x_valid  input  1  bit strobe. One bit is consumed per clk cycle with x_valid=1.
- sof  input  1  start of frame. Qualified by x_valid and marks the first data bit.
- data_out  output  DATA_BITS  recovered word. Held stable between frame_done pulses.
- frame_done  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  result of the last completed frame. Valid with frame_done and held until the next frame_done.
- busy  output  1  high while in the DATA or PARITY state.
- err_count  output  ERR_CNT_W  saturating count of parity failures. Present only with the optional feature.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, bit counter=0, running parity acc=0, shift register=0, data_out=0, frame_done=0, parity_err=0, busy=0, err_count=0.
- Bit order: data is LSB first. Bit k of a frame lands in data_out[k].
- States:
  - IDLE: on x_valid&&sof, load x into shift[0], set acc=x, set cnt=1, go to DATA. Any other x_valid is ignored (stray bits are dropped).
  - DATA: on x_valid, store x at shift[cnt], acc^=x, cnt++. When cnt reaches DATA_BITS-1 and the bit is accepted, go to PARITY.
  - PARITY: on x_valid, perform the completion actions below and return to IDLE.
- PARITY completion actions:
  - compute fail = (acc^x) != ODD_PARITY.
  - register data_out <= shift and parity_err <= fail.
  - pulse frame_done for exactly one cycle.
- Latency: frame_done, data_out and parity_err update on the clk edge that samples the parity bit. They are visible in the cycle after the parity bit is presented.
- Idle bits: cycles with x_valid=0 hold all state, with no timeout.
- sof during DATA or PARITY: the partial frame is abandoned with no frame_done and no error. The current bit starts a new frame, with the same actions as IDLE+sof. sof on the parity-bit cycle likewise restarts; that parity bit is treated as data bit 0.
- Back-to-back frames: sof may arrive in the cycle directly after the parity bit; no gap is required.
- busy: equals (state != IDLE).
- Reset mid-frame: the frame is discarded and all outputs return to their reset values immediately.
- Width rules: cnt is $clog2(DATA_BITS) bits wide. acc is 1 bit.

Optional Feature:
- Macro: SERIAL_PARITY_ERRCNT_EN.
- Defined:
  - the err_count port exists.
  - it increments on each frame_done with parity_err=1.
  - it saturates at 2^ERR_CNT_W-1 and clears only on reset.
- Undefined:
  - the err_count port and its counter logic are absent.
  - all other behaviour is identical.

Decomposition:
- Package serial_parity_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_DATA=2'd1, ST_PARITY=2'd2.
  - the parity mode constants PAR_EVEN=0, PAR_ODD=1.
- The generator and checker share this package.
- Natural sub-module: sat_counter (parameterised width, inc and rst_n inputs), used for err_count.
- The FSM and shift register stay in the top module.

Test Plan:
- Good even frame: DATA_BITS=8, ODD_PARITY=0, sof with data 0xA5 LSB first, then parity bit 0 -> next cycle frame_done=1, data_out=0xA5, parity_err=0, busy=0.
- Bad parity: same data 0xA5 with parity bit 1 -> parity_err=1, data_out=0xA5. With the macro defined, err_count goes 0->1.
- Gapped strobe with odd parity: ODD_PARITY=1, data 0x01 with x_valid low for 3 cycles between each bit, parity bit 0 -> parity_err=0, and frame_done fires only after the parity bit.
- Restart mid-frame: 4 bits of a frame, then sof with a full frame 0x3C and parity 0 -> exactly one frame_done, data_out=0x3C, parity_err=0.
- Reset mid-frame: assert rst_n=0 for 1 cycle after 5 data bits -> all outputs 0, state IDLE. Non-sof bits are then ignored until the next sof.
- Saturation (macro defined, ERR_CNT_W=2): 5 consecutive bad frames back to back -> err_count reads 1, 2, 3, 3, 3.
